mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter_rr_picker.sv | 40 ++++
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory arbiter: default widths, counter width, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int PERF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit searching upward from rr_ptr+1, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is used.
// Ports: req (request vector), rr_ptr (last winner) -> win_oh (one-hot), win_idx, any.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        sum     = '0;
        cand    = '0;
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        // Visit rr_ptr+1 .. rr_ptr+N_REQ (mod N_REQ); the last visited is rr_ptr itself,
        // so the previous winner has the lowest priority.
        for (int i = 1; i <= N_REQ; i++) begin
            sum = (IDX_W+1)'(rr_ptr) + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!any && req[cand]) begin
                any          = 1'b1;
                win_oh[cand] = 1'b1;
                win_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory among N_REQ requesters.
// Latency: gnt 1 cycle after req is sampled; write lands at edge +2; rvalid/rdata in cycle +3.
// Backpressure: requests are held until gnt; req is only looked at in IDLE, one access in flight.
// Ports: req/req_we/req_addr/req_wdata in; gnt/rvalid one-hot pulses, rdata, busy out;
//        mem_write_readBar/mem_address/mem_data_in to memory, mem_data_out from memory.
// Optional: define MEM_ARB_PERF_EN for per-requester saturating grant counters
//        (perf_grant_cnt, cleared by perf_clr); otherwise perf_grant_cnt is 0.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             req_we,
    input  logic [N_REQ*ADDR_W-1:0]      req_addr,
    input  logic [N_REQ*DATA_W-1:0]      req_wdata,
    output logic [N_REQ-1:0]             gnt,
    output logic [N_REQ-1:0]             rvalid,
    output logic [DATA_W-1:0]            rdata,
    output logic                         busy,
    output logic                         mem_write_readBar,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [DATA_W-1:0]            mem_data_in,
    input  logic [DATA_W-1:0]            mem_data_out,
    input  logic                         perf_clr,
    output logic [N_REQ*PERF_CNT_W-1:0]  perf_grant_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]   win_oh_q, win_oh_d;
    logic               we_q, we_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_din_q, mem_din_d;

    logic [N_REQ-1:0]   pk_oh;
    logic [IDX_W-1:0]   pk_idx;
    logic               pk_any;

    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_we;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .win_oh  (pk_oh),
        .win_idx (pk_idx),
        .any     (pk_any)
    );

    // Steer the winner's command fields.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pk_idx == IDX_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_we    = req_we[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_oh_d   = win_oh_q;
        we_d       = we_q;
        gnt_d      = '0;
        rvalid_d   = '0;
        rdata_d    = rdata_q;
        mem_we_d   = 1'b0;     // write strobe only ever lives in ISSUE
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        case (state_q)
            IDLE: begin
                if (pk_any) begin
                    state_d    = ISSUE;
                    gnt_d      = pk_oh;
                    rr_ptr_d   = pk_idx;
                    win_oh_d   = pk_oh;
                    we_d       = sel_we;
                    mem_we_d   = sel_we;
                    mem_addr_d = sel_addr;
                    mem_din_d  = sel_wdata;
                end
            end
            ISSUE: begin
                // Memory samples address/write at the end of this cycle.
                state_d = we_q ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                rdata_d  = mem_data_out;
                rvalid_d = win_oh_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= IDX_W'(N_REQ - 1);   // requester 0 wins first
            win_oh_q   <= '0;
            we_q       <= 1'b0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_oh_q   <= win_oh_d;
            we_q       <= we_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign gnt               = gnt_q;
    assign rvalid            = rvalid_q;
    assign rdata             = rdata_q;
    assign busy              = busy_q;
    assign mem_write_readBar = mem_we_q;
    assign mem_address       = mem_addr_q;
    assign mem_data_in       = mem_din_q;

`ifdef MEM_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] cnt_q [N_REQ];
    logic [PERF_CNT_W-1:0] cnt_d [N_REQ];

    // Counts the registered gnt pulse; clear has priority over increment.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (perf_clr) begin
                cnt_d[i] = '0;
            end else if (gnt_q[i] && (cnt_q[i] != {PERF_CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + PERF_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        perf_grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            perf_grant_cnt[i*PERF_CNT_W +: PERF_CNT_W] = cnt_q[i];
        end
    end
`else
    logic perf_clr_unused;
    assign perf_clr_unused = perf_clr;
    assign perf_grant_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus
// round-robin, withdrawal and reset-during-read sequences, against a behavioural memory.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            mem_write_readBar;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_data_in;
    logic [DW-1:0]   mem_data_out;
    logic            perf_clr;
    logic [N*16-1:0] perf_grant_cnt;

    int checks = 0;
    int errors = 0;
    int we_cycles = 0;
    int seq_got [8];

    mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .req               (req),
        .req_we            (req_we),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .gnt               (gnt),
        .rvalid            (rvalid),
        .rdata             (rdata),
        .busy              (busy),
        .mem_write_readBar (mem_write_readBar),
        .mem_address       (mem_address),
        .mem_data_in       (mem_data_in),
        .mem_data_out      (mem_data_out),
        .perf_clr          (perf_clr),
        .perf_grant_cnt    (perf_grant_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Behavioural single-port memory: registered read, unwritten words hold a pattern.
    function automatic logic [31:0] init_pat(input logic [9:0] a);
        return 32'h5A5A0000 | {22'b0, a};
    endfunction

    logic        written [1024];
    logic [31:0] wr_val  [1024];

    always @(posedge clk) begin
        if (mem_write_readBar) begin
            written[mem_address] <= 1'b1;
            wr_val[mem_address]  <= mem_data_in;
        end
        mem_data_out <= (written[mem_address] === 1'b1) ? wr_val[mem_address]
                                                        : init_pat(mem_address);
    end

    always @(negedge clk) begin
        if (mem_write_readBar) we_cycles++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          r;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    // One transaction from an idle arbiter; starts and ends on a falling edge.
    task automatic run_vec(input vec_t v);
        int c;
        bit got;
        req[v.r]                 = 1'b1;
        req_we[v.r]              = v.we;
        req_addr[v.r*AW +: AW]   = v.addr;
        req_wdata[v.r*DW +: DW]  = v.wdata;
        c = 0;
        got = 0;
        while (!got && c < 10) begin
            @(negedge clk);
            c++;
            if (gnt != 0) got = 1;
        end
        check("gnt", gnt, 64'(1) << v.r);
        check("gnt_latency", c, 1);
        check("busy_in_issue", busy, 1);
        check("mem_we_in_issue", mem_write_readBar, v.we);
        check("mem_address", mem_address, v.addr);
        if (v.we) check("mem_data_in", mem_data_in, v.wdata);
        req[v.r] = 1'b0;
        if (!v.we) begin
            got = 0;
            while (!got && c < 10) begin
                @(negedge clk);
                c++;
                if (rvalid != 0) got = 1;
            end
            check("rvalid", rvalid, 64'(1) << v.r);
            check("rvalid_latency", c, 3);
            check("rdata", rdata, v.exp_rdata);
        end
        while (busy && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("idle_after", busy, 0);
    endtask

    // Hold rq as reads and record the first n winners, then drop all requests.
    task automatic grant_seq(input logic [N-1:0] rq, input int n);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        req_we = '0;
        req = rq;
        while (got < n && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (gnt != 0) begin
                for (int k = 0; k < N; k++) if (gnt[k]) seq_got[got] = k;
                got++;
                if (got == n) req = '0;
            end
        end
        for (int k = got; k < n; k++) seq_got[k] = -1;
        cyc = 0;
        while (busy && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int exp_rr  [5];
    int exp_alt [4];

    initial begin
        int c;
        int seen_g2;
        int seen_rv;
        vec_t v;

        vecs[0] = '{r: 0, we: 1'b0, addr: 10'h000, wdata: 32'h0,        exp_rdata: 32'h5A5A0000};
        vecs[1] = '{r: 1, we: 1'b1, addr: 10'h3FF, wdata: 32'hDEADBEEF, exp_rdata: 32'h0};
        vecs[2] = '{r: 1, we: 1'b0, addr: 10'h3FF, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
        vecs[3] = '{r: 2, we: 1'b1, addr: 10'h005, wdata: 32'h12345678, exp_rdata: 32'h0};
        vecs[4] = '{r: 0, we: 1'b0, addr: 10'h3FE, wdata: 32'h0,        exp_rdata: 32'h5A5A03FE};
        vecs[5] = '{r: 3, we: 1'b0, addr: 10'h005, wdata: 32'h0,        exp_rdata: 32'h12345678};
        // Last table winner is requester 3, so a full request set starts at 0.
        exp_rr  = '{0, 1, 2, 3, 0};
        // After that sequence rr_ptr=0, so 0101 starts with requester 2.
        exp_alt = '{2, 0, 2, 0};

        reset     = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        perf_clr  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_we", mem_write_readBar, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_mem_din", mem_data_in, 0);
        check("rst_perf", perf_grant_cnt, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_req_busy", busy, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        check("we_cycles_total", we_cycles, 2);

        grant_seq(4'b1111, 5);
        for (int i = 0; i < 5; i++) check("rr_order", seq_got[i], exp_rr[i]);

        grant_seq(4'b0101, 4);
        for (int i = 0; i < 4; i++) check("alt_order", seq_got[i], exp_alt[i]);

        // Withdrawal: req[2] visible for one cycle while busy only.
        req_we = '0;
        req_addr[0*AW +: AW] = 10'h001;
        req = 4'b0001;
        c = 0;
        while (gnt == 0 && c < 10) begin
            @(negedge clk);
            c++;
        end
        check("wd_gnt0", gnt, 4'b0001);
        req = 4'b0100;
        seen_g2 = 0;
        seen_rv = 0;
        @(negedge clk);
        req = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            if (gnt[2]) seen_g2++;
            if (rvalid[0]) seen_rv++;
            @(negedge clk);
        end
        check("wd_no_gnt2", seen_g2, 0);
        check("wd_rvalid0", seen_rv, 1);

        // Reset during CAPTURE: read is dropped and outputs clear at once.
        req_addr[1*AW +: AW] = 10'h3FF;
        req = 4'b0010;
        c = 0;
        while (gnt == 0 && c < 10) begin
            @(negedge clk);
            c++;
        end
        check("mr_gnt1", gnt, 4'b0010);
        req = '0;
        @(negedge clk);
        check("mr_busy_capture", busy, 1);
        reset = 1'b1;
        #1;
        check("mr_gnt", gnt, 0);
        check("mr_rvalid", rvalid, 0);
        check("mr_rdata", rdata, 0);
        check("mr_busy", busy, 0);
        check("mr_mem_we", mem_write_readBar, 0);
        check("mr_mem_addr", mem_address, 0);
        @(negedge clk);
        reset = 1'b0;
        seen_rv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rvalid != 0) seen_rv++;
        end
        check("mr_no_rvalid", seen_rv, 0);
        v = '{r: 1, we: 1'b0, addr: 10'h3FF, wdata: 32'h0, exp_rdata: 32'hDEADBEEF};
        run_vec(v);

`ifdef MEM_ARB_PERF_EN
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        v = '{r: 0, we: 1'b1, addr: 10'h010, wdata: 32'h1, exp_rdata: 32'h0};
        for (int i = 0; i < 3; i++) run_vec(v);
        @(negedge clk);
        check("perf_cnt3", perf_grant_cnt[15:0], 16'd3);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        check("perf_clr", perf_grant_cnt[15:0], 16'd0);
        req_we = 4'b0001;
        req_addr[0*AW +: AW] = 10'h020;
        req = 4'b0001;
        repeat (65540 * 2 + 4) @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);
        check("perf_sat", perf_grant_cnt[15:0], 16'hFFFF);
        check("perf_other", perf_grant_cnt[63:16], 0);
`else
        check("perf_tied_zero", perf_grant_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
